// File: rtl/fib_checker.sv
// Fibonacci stream checker: compares each accepted term against a golden mod-2^W recurrence.
// Optional CHECKER_ERRCNT_EN: count all mismatches over a full run instead of stopping at the first.
module fib_checker #(
    parameter int unsigned W  = 32,
    parameter int unsigned N  = 100,
    parameter int unsigned CW = 7
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          valid,
    input  logic [W-1:0]  data,
    output logic          ready,
    output logic [CW-1:0] cnt,
    output logic          done,
    output logic          pass,
    output logic [CW-1:0] err_idx,
    output logic [W-1:0]  err_data,
    output logic [W-1:0]  err_exp
`ifdef CHECKER_ERRCNT_EN
    ,
    output logic [CW-1:0] err_cnt
`endif
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CHECK = 2'd1,
        S_PASS  = 2'd2,
        S_FAIL  = 2'd3
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [W-1:0] gold_a;
    logic [W-1:0] gold_b;
    logic         accept;
    logic         mismatch;
    logic         last;
    logic         first_err;

    // A beat coinciding with start is discarded so the new run begins clean.
    assign accept   = valid & ready & ~start;
    assign mismatch = (data != gold_a);
    assign last     = (cnt == CW'(N - 1));

`ifdef CHECKER_ERRCNT_EN
    assign first_err = (err_cnt == '0);
`else
    assign first_err = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (start) begin
            state_nxt = S_CHECK;
        end else if (state == S_CHECK && accept) begin
`ifdef CHECKER_ERRCNT_EN
            if (last) begin
                state_nxt = (first_err && !mismatch) ? S_PASS : S_FAIL;
            end
`else
            // A mismatch on the final beat still ends in FAIL.
            if (mismatch) begin
                state_nxt = S_FAIL;
            end else if (last) begin
                state_nxt = S_PASS;
            end
`endif
        end
    end

    always_comb begin
        ready = 1'b0;
        done  = 1'b0;
        pass  = 1'b0;
        case (state)
            S_CHECK: ready = 1'b1;
            S_PASS: begin
                done = 1'b1;
                pass = 1'b1;
            end
            S_FAIL:  done = 1'b1;
            default: ready = 1'b0;
        endcase
    end

    // Golden recurrence, beat counter and first-mismatch capture.
    always_ff @(posedge clk) begin
        if (rst || start) begin
            gold_a   <= '0;
            gold_b   <= W'(1);
            cnt      <= '0;
            err_idx  <= '0;
            err_data <= '0;
            err_exp  <= '0;
`ifdef CHECKER_ERRCNT_EN
            err_cnt  <= '0;
`endif
        end else if (accept) begin
            cnt    <= cnt + CW'(1);
            gold_a <= gold_b;
            gold_b <= gold_a + gold_b;
            if (mismatch && first_err) begin
                err_idx  <= cnt;
                err_data <= data;
                err_exp  <= gold_a;
            end
`ifdef CHECKER_ERRCNT_EN
            if (mismatch) begin
                err_cnt <= err_cnt + CW'(1);
            end
`endif
        end
    end

endmodule

// File: tb/tb_fib_checker.sv
// Randomized self-checking bench for fib_checker against a per-beat reference model.
module tb_fib_checker;

    localparam int unsigned W  = 32;
    localparam int unsigned N  = 100;
    localparam int unsigned CW = 7;
    localparam int unsigned NB = N + 6;
`ifdef CHECKER_ERRCNT_EN
    localparam bit ERRCNT = 1'b1;
`else
    localparam bit ERRCNT = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          valid;
    logic [W-1:0]  data;
    logic          ready;
    logic [CW-1:0] cnt;
    logic          done;
    logic          pass;
    logic [CW-1:0] err_idx;
    logic [W-1:0]  err_data;
    logic [W-1:0]  err_exp;
`ifdef CHECKER_ERRCNT_EN
    logic [CW-1:0] err_cnt;
`endif

    fib_checker #(.W(W), .N(N), .CW(CW)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .valid    (valid),
        .data     (data),
        .ready    (ready),
        .cnt      (cnt),
        .done     (done),
        .pass     (pass),
        .err_idx  (err_idx),
        .err_data (err_data),
        .err_exp  (err_exp)
`ifdef CHECKER_ERRCNT_EN
        ,
        .err_cnt  (err_cnt)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    logic [W-1:0] fib  [N];
    logic [W-1:0] sent [NB];

    // Reference model state for the current run.
    int           m_cnt;
    int           m_errs;
    bit           m_done;
    bit           m_pass;
    int           m_eidx;
    logic [W-1:0] m_edata;
    logic [W-1:0] m_eexp;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic model_clear();
        m_cnt   = 0;
        m_errs  = 0;
        m_done  = 1'b0;
        m_pass  = 1'b0;
        m_eidx  = 0;
        m_edata = '0;
        m_eexp  = '0;
    endtask

    task automatic check_err_fields(input string tag);
        check({tag, ".err_idx"},  64'(err_idx),  64'(m_eidx));
        check({tag, ".err_data"}, 64'(err_data), 64'(m_edata));
        check({tag, ".err_exp"},  64'(err_exp),  64'(m_eexp));
`ifdef CHECKER_ERRCNT_EN
        check({tag, ".err_cnt"},  64'(err_cnt),  64'(m_errs));
`endif
    endtask

    task automatic check_idle(input string tag);
        model_clear();
        check({tag, ".ready"}, 64'(ready), 64'(0));
        check({tag, ".done"},  64'(done),  64'(0));
        check({tag, ".pass"},  64'(pass),  64'(0));
        check({tag, ".cnt"},   64'(cnt),   64'(0));
        check_err_fields(tag);
    endtask

    task automatic fill_clean();
        for (int i = 0; i < int'(NB); i++) begin
            sent[i] = (i < int'(N)) ? fib[i] : W'($urandom);
        end
    endtask

    // Start pulse, possibly with a simultaneous beat that must be ignored.
    task automatic pulse_start(input string tag);
        start = 1'b1;
        valid = 1'($urandom_range(0, 1));
        data  = '0;
        @(negedge clk);
        start = 1'b0;
        valid = 1'b0;
        model_clear();
        check({tag, ".start_ready"}, 64'(ready), 64'(1));
        check({tag, ".start_done"},  64'(done),  64'(0));
        check({tag, ".start_pass"},  64'(pass),  64'(0));
        check({tag, ".start_cnt"},   64'(cnt),   64'(0));
        check_err_fields({tag, ".start"});
    endtask

    task automatic send_beat(input string tag, input logic [W-1:0] v);
        bit bad;
        valid = 1'b1;
        data  = v;
        if (!m_done) begin
            bad = (v != fib[m_cnt]);
            if (bad) begin
                if (m_errs == 0) begin
                    m_eidx  = m_cnt;
                    m_edata = v;
                    m_eexp  = fib[m_cnt];
                end
                m_errs++;
            end
            m_cnt++;
            if (bad && !ERRCNT) begin
                m_done = 1'b1;
                m_pass = 1'b0;
            end else if (m_cnt == int'(N)) begin
                m_done = 1'b1;
                m_pass = (m_errs == 0);
            end
        end
        @(negedge clk);
        valid = 1'b0;
        data  = W'($urandom);
        check({tag, ".cnt"},   64'(cnt),   64'(m_cnt));
        check({tag, ".done"},  64'(done),  64'(m_done));
        check({tag, ".pass"},  64'(pass),  64'(m_pass));
        check({tag, ".ready"}, 64'(ready), 64'(!m_done));
    endtask

    task automatic run(input string tag, input int nb, input int max_gap);
        for (int i = 0; i < nb; i++) begin
            send_beat(tag, sent[i]);
            repeat ($urandom_range(0, max_gap)) @(negedge clk);
        end
        check_err_fields(tag);
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        valid = 1'b0;
        data  = '0;
        fib[0] = '0;
        fib[1] = W'(1);
        for (int i = 2; i < int'(N); i++) fib[i] = fib[i-1] + fib[i-2];

        repeat (3) @(negedge clk);
        rst = 1'b0;
        check_idle("reset");

        // Beats in IDLE before any start must be dropped.
        for (int i = 0; i < 5; i++) begin
            valid = 1'b1;
            data  = W'($urandom);
            @(negedge clk);
        end
        valid = 1'b0;
        check_idle("idle_valid");

        fill_clean();
        pulse_start("clean");
        run("clean", NB, 0);

        fill_clean();
        sent[47] = 32'd2971215073;
        sent[48] = 32'd512559680;
        pulse_start("wrap");
        run("wrap", NB, 0);

        fill_clean();
        sent[10] = 32'd56;
        pulse_start("bad10");
        run("bad10", NB, 0);

        fill_clean();
        sent[3]  = fib[3] + 32'd1;
        sent[50] = ~fib[50];
        pulse_start("bad3_50");
        run("bad3_50", NB, 1);

        for (int k = 0; k < 4; k++) begin
            int pos;
            fill_clean();
            pos = int'($urandom_range(0, N - 1));
            sent[pos] = sent[pos] ^ (32'd1 << $urandom_range(0, 31));
            pulse_start("rand_bad");
            run("rand_bad", NB, 3);
        end

        fill_clean();
        pulse_start("gaps");
        run("gaps", NB, 5);

        fill_clean();
        pulse_start("abort");
        run("abort", 20, 2);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_idle("abort_rst");
        pulse_start("after_rst");
        run("after_rst", NB, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
